// File: rtl/arb_req_fifo_bank.sv
// arb_req_fifo_bank: four-port request-queue bank that feeds a round-robin arbiter.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wr_en, wr_data  per-port write strobe and word (port i at [i*DATA_W +: DATA_W])
//   full, req       per-port FIFO full / non-empty, decoded from the registered count
//   gnt             arbiter grant, expected one-hot or zero
//   out_valid, out_data, out_src  registered popped word and its source port
//   ovf, gnt_err    sticky per-port overflow and non-one-hot-grant flags
module arb_req_fifo_bank #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          wr_en,
    input  logic [4*DATA_W-1:0] wr_data,
    output logic [3:0]          full,
    output logic [3:0]          req,
    input  logic [3:0]          gnt,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [1:0]          out_src,
    output logic [3:0]          ovf,
    output logic                gnt_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [4][DEPTH];
    logic [DATA_W-1:0] mem_d [4][DEPTH];
    logic [AW-1:0]     rd_ptr_q [4];
    logic [AW-1:0]     rd_ptr_d [4];
    logic [AW-1:0]     wr_ptr_q [4];
    logic [AW-1:0]     wr_ptr_d [4];
    logic [AW:0]       cnt_q [4];
    logic [AW:0]       cnt_d [4];
    logic [3:0]        ovf_q, ovf_d;
    logic              gnt_err_q, gnt_err_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [1:0]        out_src_q, out_src_d;
    logic [3:0]        push, pop;
    logic              gnt_multi, gnt_onehot;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign gnt_multi  = |(gnt & (gnt - 4'd1));
    assign gnt_onehot = (gnt != 4'd0) && !gnt_multi;

    always_comb begin
        mem_d       = mem_q;
        ovf_d       = ovf_q;
        gnt_err_d   = gnt_err_q | gnt_multi;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        push        = '0;
        pop         = '0;
        for (int i = 0; i < 4; i++) begin
            // Fullness is judged on the registered count, so a write into a full
            // FIFO is dropped even when the same port pops this cycle.
            push[i]     = wr_en[i] && (cnt_q[i] != FULL_CNT);
            pop[i]      = gnt_onehot && gnt[i] && (cnt_q[i] != '0);
            rd_ptr_d[i] = pop[i] ? rd_ptr_q[i] + AW'(1) : rd_ptr_q[i];
            wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + AW'(1) : wr_ptr_q[i];
            cnt_d[i]    = (push[i] && !pop[i]) ? cnt_q[i] + (AW+1)'(1) :
                          (pop[i] && !push[i]) ? cnt_q[i] - (AW+1)'(1) : cnt_q[i];
            if (push[i])
                mem_d[i][wr_ptr_q[i]] = wr_data[i*DATA_W +: DATA_W];
            if (wr_en[i] && !push[i])
                ovf_d[i] = 1'b1;
            if (pop[i]) begin
                out_valid_d = 1'b1;
                out_data_d  = mem_q[i][rd_ptr_q[i]];
                out_src_d   = 2'(i);
            end
        end
    end

    // Storage needs no reset: emptiness is tracked by the counts alone.
    always_ff @(posedge clk)
        mem_q <= mem_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q    <= '{default: '0};
            wr_ptr_q    <= '{default: '0};
            cnt_q       <= '{default: '0};
            ovf_q       <= '0;
            gnt_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            gnt_err_q   <= gnt_err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    always_comb begin
        full = '0;
        req  = '0;
        for (int i = 0; i < 4; i++) begin
            full[i] = cnt_q[i] == FULL_CNT;
            req[i]  = cnt_q[i] != '0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign ovf       = ovf_q;
    assign gnt_err   = gnt_err_q;
endmodule

// File: doc/arb_req_fifo_bank.md
# arb_req_fifo_bank

Four-port request-queue bank that sits directly upstream of the fixed-time-slice round-robin arbiter. Each port buffers write words in a small FIFO and asserts `req[i]` while its FIFO holds data. Each cycle that the arbiter drives `gnt[i]`, the bank pops one word from FIFO i. The popped word is presented one cycle later on a single registered output, tagged with its source port.

## Interface
Parameters
- `DATA_W`, default 8: width of one queued word.
- `DEPTH`, default 4: entries per port FIFO. Must be a power of 2 and ≥ 2.

Ports (clock and reset first)
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `wr_en`  in  4  per-port write strobe.
- `wr_data`  in  4*DATA_W  per-port write word; port i occupies bits [i*DATA_W +: DATA_W].
- `full`  out  4  per-port FIFO full, i.e. count == DEPTH.
- `req`  out  4  per-port request to the arbiter, i.e. count != 0.
- `gnt`  in  4  grant from the arbiter; at most one bit is expected high.
- `out_valid`  out  1  registered; high for one cycle per popped word.
- `out_data`  out  DATA_W  registered popped word.
- `out_src`  out  2  registered index of the port that was popped.
- `ovf`  out  4  sticky per-port overflow flag.
- `gnt_err`  out  1  sticky flag: a non-one-hot grant was received.

## Operation
- Each port has a circular FIFO:
  - Storage: DEPTH × DATA_W.
  - Pointers: rd_ptr and wr_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - Count: log2(DEPTH)+1 bits, range 0..DEPTH.
- `req` and `full` are decoded purely from the registered count. They have no combinational path from `wr_en` or `gnt`.
- **Write, port i:**
  - If wr_en[i] and count < DEPTH, write the word at wr_ptr and increment wr_ptr.
  - If wr_en[i] and count == DEPTH, drop the word and set ovf[i]. This applies even if the port pops in the same cycle.
- **Pop, port i:**
  - Occurs when gnt is exactly one-hot with bit i set and req[i] = 1.
  - The head word is read from rd_ptr and rd_ptr increments.
- **Simultaneous write and pop on the same port:** both take effect and count is unchanged.
- **Write to an empty FIFO:** no bypass. The word becomes the head and req[i] rises on the next cycle.
- **Grant to an empty port** (gnt one-hot, req[i] = 0): no pop, out_valid = 0, no error flagged.
- **Non-one-hot grant** (two or more bits set): no pop on any port, out_valid = 0, gnt_err set. gnt = 0 is legal and idle.
- **Output register:**
  - On a pop: out_valid ← 1, out_data ← head word, out_src ← i.
  - Otherwise out_valid ← 0, and out_data / out_src hold their last values.
- Sticky flags clear only on rst.
- **Reset values:**
  - All pointers and counts 0, so req = 0 and full = 0.
  - out_valid = 0, out_data = 0, out_src = 0.
  - ovf = 0, gnt_err = 0.
  - Reset is honoured mid-transfer. Queued data is discarded.

## Timing
- Write → req: wr_en[i] sampled at edge N into an empty FIFO; req[i] = 1 after edge N.
- Pop → output: gnt[i] high in the cycle before edge N; out_valid = 1 and the word are visible after edge N (1-cycle latency).
- Back-to-back: sustained gnt[i] pops one word per cycle. out_valid stays high for consecutive cycles with data in FIFO order.
- Last word: the pop that makes count = 0 drops req[i] after the same edge. The arbiter then sees ~req[i] and moves on. No extra pop occurs because req[i] = 0 gates it.
- Arbiter slice: the arbiter holds gnt[i] for at most 4 cycles, so a full DEPTH = 4 FIFO drains in one slice.
- full[i] falls the cycle after a pop from a full FIFO. A write in that same pop cycle is still dropped.

## Test plan
- **Reset and idle:** assert rst mid-run with port 1 holding 2 words → req = 0, full = 0, out_valid = 0, ovf = 0, gnt_err = 0. After release with gnt = 0001, no output.
- **Ordered drain:** write 0x11, 0x22, 0x33 to port 2; hold gnt = 0100 for 4 cycles → out_data 0x11, 0x22, 0x33 on 3 consecutive cycles with out_src = 2, then out_valid = 0. req[2] falls after the 3rd pop.
- **Full and overflow:** write 5 words 0xA0..0xA4 to port 0 with no grant → full[0] = 1 after the 4th write, 0xA4 dropped, ovf[0] = 1. Drain returns 0xA0..0xA3. ovf[0] stays 1.
- **Wrap-around:** on port 3, repeat write 3 / pop 3 three times, for 9 words total across a pointer wrap → output order matches input 0x01..0x09 with no loss.
- **Simultaneous write and pop:** port 1 holds 2 words; write 0x55 while gnt = 0010 → one word out, count stays 2, and 0x55 eventually emerges last.
- **Bad grant:** gnt = 0011 with ports 0 and 1 non-empty → no pop, out_valid = 0, gnt_err = 1. Counts unchanged. The following gnt = 0001 pops normally.
